// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding, instruction codes and
// the Capture-IR pattern used by jtag_tap_responder and jtag_tap_fsm.
package jtag_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR        = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR        = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_TEST_IDLE    = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tapState_e;

   typedef enum logic [1:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_USER
   } drSel_e;

   // Cast to the IR width at the point of use; -1 becomes all-ones.
   localparam int INSTR_IDCODE = 1;
   localparam int INSTR_USER   = 2;
   localparam int INSTR_BYPASS = -1;

   localparam logic [1:0] CAPTURE_IR_LSBS = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller; moves one state per advance pulse,
// forceReset parks it in TEST_LOGIC_RESET.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      advance,
   input  logic      tms,
   input  logic      forceReset,
   output tapState_e state,
   output tapState_e nextState
);

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values; blocking here would create simulation order races.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= TEST_LOGIC_RESET;
      else if (forceReset)
         state <= TEST_LOGIC_RESET;
      else if (advance)
         state <= nextState;
   end

   // NOTE: nextState gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      nextState = state;
      case (state)
         TEST_LOGIC_RESET: nextState = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    nextState = tms ? SELECT_DR        : RUN_TEST_IDLE;
         SELECT_DR:        nextState = tms ? SELECT_IR        : CAPTURE_DR;
         CAPTURE_DR:       nextState = tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         nextState = tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         nextState = tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         nextState = tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         nextState = tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        nextState = tms ? SELECT_DR        : RUN_TEST_IDLE;
         SELECT_IR:        nextState = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       nextState = tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         nextState = tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         nextState = tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         nextState = tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         nextState = tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        nextState = tms ? SELECT_DR        : RUN_TEST_IDLE;
         default:          nextState = TEST_LOGIC_RESET;
      endcase
   end

endmodule

// File: rtl/jtag_tap_responder.sv
// Oversampling JTAG TAP target with IR, BYPASS, IDCODE and one user DR.
// Optional macro JTAG_TRST_EN adds a synchronized trst input.
module jtag_tap_responder
   import jtag_pkg::*;
#(
   parameter int          IR_WIDTH      = 4,
   parameter logic [31:0] IDCODE_VALUE  = 32'h1BA0_0477,
   parameter int          USER_DR_WIDTH = 8,
   parameter int          SYNC_STAGES   = 2
) (
   input  logic                     clock,
   input  logic                     reset,
`ifdef JTAG_TRST_EN
   input  logic                     trst,
`endif
   input  logic                     tck,
   input  logic                     tms,
   input  logic                     tdi,
   output logic                     tdo,
   output logic                     tdo_oe,
   output logic [3:0]               tap_state,
   output logic [IR_WIDTH-1:0]      ir_value,
   input  logic [USER_DR_WIDTH-1:0] user_dr_in,
   output logic [USER_DR_WIDTH-1:0] user_dr_out,
   output logic                     user_dr_upd
);

   logic [SYNC_STAGES-1:0]   tckSync, tmsSync, tdiSync;
   logic                     syncTck, syncTms, syncTdi, tckPrev;
   logic                     tckRise, tckFall, trstHold;
   tapState_e                tapState, fsmNext;
   drSel_e                   drSel;
   logic [IR_WIDTH-1:0]      irShift;
   logic [31:0]              idcodeShift;
   logic [USER_DR_WIDTH-1:0] userShift;
   logic                     bypassReg, activeLsb;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tckSync <= '0;
         tmsSync <= '0;
         tdiSync <= '0;
         tckPrev <= 1'b0;
      end else begin
         tckSync <= {tckSync[SYNC_STAGES-2:0], tck};
         tmsSync <= {tmsSync[SYNC_STAGES-2:0], tms};
         tdiSync <= {tdiSync[SYNC_STAGES-2:0], tdi};
         tckPrev <= syncTck;
      end
   end

`ifdef JTAG_TRST_EN
   logic [SYNC_STAGES-1:0] trstSync;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         trstSync <= '0;
      else
         trstSync <= {trstSync[SYNC_STAGES-2:0], trst};
   end

   assign trstHold = trstSync[SYNC_STAGES-1];
`else
   assign trstHold = 1'b0;
`endif

   assign syncTck   = tckSync[SYNC_STAGES-1];
   assign syncTms   = tmsSync[SYNC_STAGES-1];
   assign syncTdi   = tdiSync[SYNC_STAGES-1];
   assign tckRise   = syncTck & ~tckPrev;
   assign tckFall   = ~syncTck & tckPrev;
   assign tap_state = tapState;

   jtag_tap_fsm u_fsm (
      .clock      (clock),
      .reset      (reset),
      .advance    (tckRise),
      .tms        (syncTms),
      .forceReset (trstHold),
      .state      (tapState),
      .nextState  (fsmNext)
   );

   // All-ones and every undefined code fall through to the bypass bit.
   always_comb begin
      drSel = DR_BYPASS;
      case (ir_value)
         IR_WIDTH'(INSTR_IDCODE): drSel = DR_IDCODE;
         IR_WIDTH'(INSTR_USER):   drSel = DR_USER;
         IR_WIDTH'(INSTR_BYPASS): drSel = DR_BYPASS;
         default:                 drSel = DR_BYPASS;
      endcase
   end

   always_comb begin
      activeLsb = bypassReg;
      if (tapState == SHIFT_IR)
         activeLsb = irShift[0];
      else if (drSel == DR_IDCODE)
         activeLsb = idcodeShift[0];
      else if (drSel == DR_USER)
         activeLsb = userShift[0];
   end

   // Capture, shift and update act on the rising tck edge that leaves the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         irShift     <= '0;
         idcodeShift <= '0;
         userShift   <= '0;
         bypassReg   <= 1'b0;
         ir_value    <= IR_WIDTH'(INSTR_IDCODE);
         user_dr_out <= '0;
         user_dr_upd <= 1'b0;
         tdo         <= 1'b0;
         tdo_oe      <= 1'b0;
      end else begin
         user_dr_upd <= 1'b0;
         if (tckRise) begin
            case (tapState)
               CAPTURE_IR: irShift <= IR_WIDTH'(CAPTURE_IR_LSBS);
               SHIFT_IR:   irShift <= {syncTdi, irShift[IR_WIDTH-1:1]};
               UPDATE_IR:  ir_value <= irShift;
               CAPTURE_DR: begin
                  case (drSel)
                     DR_IDCODE: idcodeShift <= IDCODE_VALUE;
                     DR_USER:   userShift   <= user_dr_in;
                     default:   bypassReg   <= 1'b0;
                  endcase
               end
               SHIFT_DR: begin
                  case (drSel)
                     DR_IDCODE: idcodeShift <= {syncTdi, idcodeShift[31:1]};
                     DR_USER:   userShift   <= {syncTdi, userShift[USER_DR_WIDTH-1:1]};
                     default:   bypassReg   <= syncTdi;
                  endcase
               end
               UPDATE_DR: begin
                  if (drSel == DR_USER) begin
                     user_dr_out <= userShift;
                     user_dr_upd <= 1'b1;
                  end
               end
               default: ;
            endcase
            if (fsmNext == TEST_LOGIC_RESET)
               ir_value <= IR_WIDTH'(INSTR_IDCODE);
         end
         if (tckFall) begin
            tdo    <= activeLsb;
            tdo_oe <= (tapState == SHIFT_IR) || (tapState == SHIFT_DR);
         end
         if (trstHold) begin
            ir_value <= IR_WIDTH'(INSTR_IDCODE);
            tdo_oe   <= 1'b0;
         end
      end
   end

endmodule
